// File: rtl/wm_plant_model.sv
// rtl/wm_plant_model.sv - washing-machine plant and sensor emulator
module wm_plant_model #(
  parameter int LEVEL_W     = 4,
  parameter int LEVEL_MAX   = 8,
  parameter int WASH_CYCLES = 20,
  parameter int SPIN_CYCLES = 10,
  parameter int DET_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_fillvalve_on,
  input  logic               i_drainvalve_on,
  input  logic               i_motor_on,
  input  logic               i_soap_wash,
  input  logic               i_doorlock,
  output logic               o_filled,
  output logic               o_drained,
  output logic               o_detergent,
  output logic               o_cycletime_out,
  output logic               o_spintime_out,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_fault,
  output logic [1:0]         o_fault_code
);

  typedef enum logic [1:0] {
    DET_IDLE     = 2'd0,
    DET_DISPENSE = 2'd1,
    DET_DONE     = 2'd2
  } det_state_t;

  localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(LEVEL_MAX);
  localparam logic [CNT_W-1:0]   WASH_END = CNT_W'(WASH_CYCLES);
  localparam logic [CNT_W-1:0]   SPIN_END = CNT_W'(SPIN_CYCLES);
  localparam logic [CNT_W-1:0]   DET_LAST = CNT_W'(DET_CYCLES - 1);

  logic [LEVEL_W-1:0] r_level;
  logic [CNT_W-1:0]   r_wash_cnt;
  logic [CNT_W-1:0]   r_spin_cnt;
  logic [CNT_W-1:0]   r_det_cnt;
  det_state_t         r_det_state;
  logic               r_fault;
  logic [1:0]         r_fault_code;

  logic               w_filled;
  logic               w_drained;
  logic [1:0]         w_fault_now;

  assign w_filled  = (r_level == LVL_FULL);
  assign w_drained = (r_level == '0);

  // Highest-priority fault condition present this clock (00 = none)
  always_comb begin
    w_fault_now = 2'b00;
    if (i_fillvalve_on && i_drainvalve_on)
      w_fault_now = 2'b01;
    else if ((i_fillvalve_on || i_drainvalve_on || i_motor_on) && !i_doorlock)
      w_fault_now = 2'b10;
    else if (i_motor_on && w_drained)
      w_fault_now = 2'b11;
  end

  // Water level: one step per clock, saturating, held when both valves are open
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_level <= '0;
    else if (i_fillvalve_on && !i_drainvalve_on && !w_filled)
      r_level <= r_level + 1'b1;
    else if (i_drainvalve_on && !i_fillvalve_on && !w_drained)
      r_level <= r_level - 1'b1;
  end

  // Wash timer: runs only with a full tub, cleared as soon as the motor stops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_wash_cnt <= '0;
    else if (!i_motor_on)
      r_wash_cnt <= '0;
    else if (w_filled && (r_wash_cnt != WASH_END))
      r_wash_cnt <= r_wash_cnt + 1'b1;
  end

  // Spin timer: runs while draining an empty, locked drum
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_spin_cnt <= '0;
    else if (!i_drainvalve_on)
      r_spin_cnt <= '0;
    else if (w_drained && i_doorlock && (r_spin_cnt != SPIN_END))
      r_spin_cnt <= r_spin_cnt + 1'b1;
  end

  // Detergent dispenser; a soap_wash drop always wins over completion
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_det_state <= DET_IDLE;
      r_det_cnt   <= '0;
    end else begin
      case (r_det_state)
        DET_IDLE: begin
          r_det_cnt <= '0;
          if (i_soap_wash && w_filled)
            r_det_state <= DET_DISPENSE;
        end
        DET_DISPENSE: begin
          if (!i_soap_wash) begin
            r_det_state <= DET_IDLE;
            r_det_cnt   <= '0;
          end else if (r_det_cnt == DET_LAST) begin
            r_det_state <= DET_DONE;
          end else begin
            r_det_cnt <= r_det_cnt + 1'b1;
          end
        end
        DET_DONE: begin
          if (!i_soap_wash) begin
            r_det_state <= DET_IDLE;
            r_det_cnt   <= '0;
          end
        end
        default: begin
          r_det_state <= DET_IDLE;
          r_det_cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky fault flag; the code of the first fault is kept until reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
    end else if (!r_fault && (w_fault_now != 2'b00)) begin
      r_fault      <= 1'b1;
      r_fault_code <= w_fault_now;
    end
  end

  assign o_filled        = w_filled;
  assign o_drained       = w_drained;
  assign o_detergent     = (r_det_state == DET_DONE);
  assign o_cycletime_out = (r_wash_cnt == WASH_END);
  assign o_spintime_out  = (r_spin_cnt == SPIN_END);
  assign o_level         = r_level;
  assign o_fault         = r_fault;
  assign o_fault_code    = r_fault_code;

endmodule

// File: tb/tb_wm_plant_model.sv
// tb/tb_wm_plant_model.sv - directed self-checking bench for wm_plant_model
module tb_wm_plant_model;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_fillvalve_on = 1'b0;
  logic       i_drainvalve_on = 1'b0;
  logic       i_motor_on = 1'b0;
  logic       i_soap_wash = 1'b0;
  logic       i_doorlock = 1'b0;
  logic       o_filled;
  logic       o_drained;
  logic       o_detergent;
  logic       o_cycletime_out;
  logic       o_spintime_out;
  logic [3:0] o_level;
  logic       o_fault;
  logic [1:0] o_fault_code;

  int n_tests = 0;
  int n_fail  = 0;

  wm_plant_model dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_fillvalve_on (i_fillvalve_on),
    .i_drainvalve_on(i_drainvalve_on),
    .i_motor_on     (i_motor_on),
    .i_soap_wash    (i_soap_wash),
    .i_doorlock     (i_doorlock),
    .o_filled       (o_filled),
    .o_drained      (o_drained),
    .o_detergent    (o_detergent),
    .o_cycletime_out(o_cycletime_out),
    .o_spintime_out (o_spintime_out),
    .o_level        (o_level),
    .o_fault        (o_fault),
    .o_fault_code   (o_fault_code)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle 1 time unit past it
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #2;
    step(1);
    i_rst = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    check_eq("rst_level", o_level, 0);
    check_eq("rst_drained", o_drained, 1);
    check_eq("rst_filled", o_filled, 0);
    check_eq("rst_det", o_detergent, 0);
    check_eq("rst_cyc", o_cycletime_out, 0);
    check_eq("rst_spin", o_spintime_out, 0);
    check_eq("rst_fault", o_fault, 0);
    check_eq("rst_code", o_fault_code, 0);
    step(1);
    i_rst = 1'b0;

    // 1: fill from empty
    i_doorlock = 1'b1;
    i_fillvalve_on = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check_eq($sformatf("fill_level_%0d", k), o_level, k);
      check_eq($sformatf("fill_filled_%0d", k), o_filled, (k == 8) ? 1 : 0);
      check_eq($sformatf("fill_drained_%0d", k), o_drained, 0);
    end
    step(2);
    check_eq("fill_sat_level", o_level, 8);
    check_eq("fill_sat_filled", o_filled, 1);
    i_fillvalve_on = 1'b0;

    // 2: detergent dispense, then an aborted dispense
    i_soap_wash = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check_eq($sformatf("det_%0d", k), o_detergent, (k == 5) ? 1 : 0);
    end
    step(2);
    check_eq("det_hold", o_detergent, 1);
    i_soap_wash = 1'b0;
    step(1);
    check_eq("det_release", o_detergent, 0);
    i_soap_wash = 1'b1;
    step(2);
    i_soap_wash = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check_eq($sformatf("det_abort_%0d", k), o_detergent, 0);
    end
    i_soap_wash = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check_eq($sformatf("det_again_%0d", k), o_detergent, (k == 5) ? 1 : 0);
    end
    i_soap_wash = 1'b0;
    step(1);

    // 3: wash timer
    i_motor_on = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      check_eq($sformatf("wash_%0d", k), o_cycletime_out, (k >= 20) ? 1 : 0);
    end
    i_motor_on = 1'b0;
    step(1);
    check_eq("wash_fall", o_cycletime_out, 0);
    i_motor_on = 1'b1;
    step(19);
    check_eq("wash_restart_19", o_cycletime_out, 0);
    step(1);
    check_eq("wash_restart_20", o_cycletime_out, 1);
    i_motor_on = 1'b0;
    step(1);
    check_eq("wash_nofault", o_fault, 0);

    // 4: drain and spin timer
    i_drainvalve_on = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check_eq($sformatf("drain_level_%0d", k), o_level, 8 - k);
      check_eq($sformatf("drain_drained_%0d", k), o_drained, (k == 8) ? 1 : 0);
    end
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check_eq($sformatf("spin_%0d", k), o_spintime_out, (k == 10) ? 1 : 0);
    end
    step(1);
    check_eq("spin_hold", o_spintime_out, 1);
    check_eq("spin_level_sat", o_level, 0);
    i_drainvalve_on = 1'b0;
    step(1);
    check_eq("spin_clear", o_spintime_out, 0);
    check_eq("spin_nofault", o_fault, 0);

    // 5: fill&drain with door unlocked -> code 01, level held
    i_fillvalve_on = 1'b1;
    step(3);
    check_eq("f5_level_pre", o_level, 3);
    i_drainvalve_on = 1'b1;
    i_doorlock = 1'b0;
    step(1);
    check_eq("f5_fault", o_fault, 1);
    check_eq("f5_code", o_fault_code, 1);
    check_eq("f5_level_held", o_level, 3);
    i_fillvalve_on = 1'b0;
    i_doorlock = 1'b1;
    step(3);
    check_eq("f5_drained", o_drained, 1);
    i_drainvalve_on = 1'b0;
    i_motor_on = 1'b1;
    step(1);
    check_eq("f5_code_kept", o_fault_code, 1);
    check_eq("f5_fault_kept", o_fault, 1);
    i_motor_on = 1'b0;

    // 6: async reset mid-wash (fault still set from above)
    i_fillvalve_on = 1'b1;
    step(8);
    i_fillvalve_on = 1'b0;
    i_motor_on = 1'b1;
    step(12);
    check_eq("r6_level_pre", o_level, 8);
    check_eq("r6_cyc_pre", o_cycletime_out, 0);
    check_eq("r6_fault_pre", o_fault, 1);
    i_rst = 1'b1;
    #2;
    check_eq("r6_level", o_level, 0);
    check_eq("r6_drained", o_drained, 1);
    check_eq("r6_cyc", o_cycletime_out, 0);
    check_eq("r6_fault", o_fault, 0);
    check_eq("r6_code", o_fault_code, 0);
    i_motor_on = 1'b0;
    step(1);
    i_rst = 1'b0;

    // priority: motor at empty with door unlocked -> 10 beats 11
    i_doorlock = 1'b0;
    i_motor_on = 1'b1;
    step(1);
    check_eq("prio_fault", o_fault, 1);
    check_eq("prio_code10", o_fault_code, 2);
    i_motor_on = 1'b0;
    do_reset();

    // motor dry run alone -> 11
    i_doorlock = 1'b1;
    step(1);
    check_eq("dry_nofault", o_fault, 0);
    i_motor_on = 1'b1;
    step(1);
    check_eq("dry_code11", o_fault_code, 3);
    i_motor_on = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
